// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Pipeline hazard control for the 16-bit core. It covers load-use
//            hazards, branch redirects and multiply/divide occupancy.
//            Optional stall-cycle statistics are enabled by HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller #(
  parameter int REG_BITS      = 4,
  parameter int MULDIV_CYCLES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REG_BITS-1:0] idRs,
  input  logic [REG_BITS-1:0] idRt,
  input  logic                idUsesRt,
  input  logic                idIsMulDiv,
  input  logic                exMemRead,
  input  logic [REG_BITS-1:0] exRd,
  input  logic                branchTaken,
  output logic                pcWrite,
  output logic                ifIdHold,
  output logic                ifIdFlush,
  output logic                idExBubble,
  output logic                busy,
  output logic [15:0]         stallCycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULDIV  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // The first stall cycle is spent in RUN, so MULDIV loads the remaining count minus one.
  localparam logic [7:0] c_MD_INIT = (MULDIV_CYCLES >= 2) ? 8'(MULDIV_CYCLES - 2) : 8'd0;
  localparam logic       c_MD_ONE  = (MULDIV_CYCLES == 1);

  state_t     r_state;
  logic [7:0] r_cnt;

  logic w_lu;
  logic w_pc_write;
  logic w_if_id_hold;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_busy;

  assign w_lu = exMemRead && (exRd != '0) &&
                ((exRd == idRs) || (idUsesRt && (exRd == idRt)));

  always_comb begin
    w_pc_write     = 1'b0;
    w_if_id_hold   = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_busy         = 1'b0;
    case (r_state)
      RUN: begin
        if (branchTaken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (w_lu) begin
          w_pc_write     = 1'b1;
          w_if_id_hold   = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (idIsMulDiv) begin
          w_pc_write     = 1'b1;
          w_if_id_hold   = 1'b1;
          w_id_ex_bubble = 1'b1;
          w_busy         = 1'b1;
        end
      end
      MULDIV: begin
        if (branchTaken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else begin
          w_pc_write     = 1'b1;
          w_if_id_hold   = 1'b1;
          w_id_ex_bubble = 1'b1;
          w_busy         = 1'b1;
        end
      end
      RELEASE: begin
        // The held instruction moves on; it must not retrigger its own stall.
        if (branchTaken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end
      end
      default: begin
        w_pc_write     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (!branchTaken && !w_lu && idIsMulDiv) begin
            if (c_MD_ONE) begin
              r_state <= RELEASE;
            end else begin
              r_state <= MULDIV;
              r_cnt   <= c_MD_INIT;
            end
          end
        end
        MULDIV: begin
          if (branchTaken) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
          end else if (r_cnt == 8'd0) begin
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RELEASE: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign pcWrite    = w_pc_write;
  assign ifIdHold   = w_if_id_hold;
  assign ifIdFlush  = w_if_id_flush;
  assign idExBubble = w_id_ex_bubble;
  assign busy       = w_busy;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stallCycles = r_stall_cnt;
`else
  assign stallCycles = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Self-checking bench for hazard_controller (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] idRs = '0, idRt = '0, exRd = '0;
  logic       idUsesRt = 1'b0, idIsMulDiv = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0;
  logic       pcWrite, ifIdHold, ifIdFlush, idExBubble, busy;
  logic [15:0] stallCycles;
  logic       pcWrite1, ifIdHold1, ifIdFlush1, idExBubble1, busy1;
  logic [15:0] stallCycles1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  hazard_controller #(.REG_BITS(4), .MULDIV_CYCLES(N)) dut (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .idIsMulDiv(idIsMulDiv), .exMemRead(exMemRead), .exRd(exRd), .branchTaken(branchTaken),
    .pcWrite(pcWrite), .ifIdHold(ifIdHold), .ifIdFlush(ifIdFlush), .idExBubble(idExBubble),
    .busy(busy), .stallCycles(stallCycles)
  );

  hazard_controller #(.REG_BITS(4), .MULDIV_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .idIsMulDiv(idIsMulDiv), .exMemRead(exMemRead), .exRd(exRd), .branchTaken(branchTaken),
    .pcWrite(pcWrite1), .ifIdHold(ifIdHold1), .ifIdFlush(ifIdFlush1), .idExBubble(idExBubble1),
    .busy(busy1), .stallCycles(stallCycles1)
  );

  // {pcWrite, ifIdHold, ifIdFlush, idExBubble, busy}
  localparam logic [4:0] IDLE  = 5'b00000;
  localparam logic [4:0] LUSTL = 5'b11010;
  localparam logic [4:0] MDSTL = 5'b11011;
  localparam logic [4:0] FLUSH = 5'b00110;

  function automatic logic [4:0] outs();
    return {pcWrite, ifIdHold, ifIdFlush, idExBubble, busy};
  endfunction

  function automatic logic [4:0] outs1();
    return {pcWrite1, ifIdHold1, ifIdFlush1, idExBubble1, busy1};
  endfunction

  // Drive one cycle of inputs just after the edge, then settle at the falling edge.
  task automatic apply(input logic rst, input logic [3:0] rs, input logic [3:0] rt,
                       input logic usert, input logic md, input logic mr,
                       input logic [3:0] rd, input logic br);
    @(posedge clock);
    #1;
    reset = rst; idRs = rs; idRt = rt; idUsesRt = usert; idIsMulDiv = md;
    exMemRead = mr; exRd = rd; branchTaken = br;
    @(negedge clock);
  endtask

  task automatic idle();
    apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", outs(), IDLE);
    end
    n_checks++;
    if (stallCycles !== 16'd0) begin
      n_fail++; $display("FAIL reset_stats: got %0d want 0", stallCycles);
    end
  endtask

  task automatic test_load_use();
    apply(1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    n_checks++;
    if (outs() !== LUSTL) begin
      n_fail++; $display("FAIL lu_stall: got %b want %b", outs(), LUSTL);
    end
    idle();
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL lu_after: got %b want %b", outs(), IDLE);
    end
    apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL lu_r0: got %b want %b", outs(), IDLE);
    end
  endtask

  task automatic test_rt_gating();
    apply(1'b0, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL rt_unused: got %b want %b", outs(), IDLE);
    end
    apply(1'b0, 4'd2, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
    n_checks++;
    if (outs() !== LUSTL) begin
      n_fail++; $display("FAIL rt_used: got %b want %b", outs(), LUSTL);
    end
    idle();
  endtask

  task automatic test_muldiv();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < N; i++) begin
        apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        n_checks++;
        if (outs() !== MDSTL) begin
          n_fail++; $display("FAIL md_stall rep%0d cyc%0d: got %b want %b", rep, i, outs(), MDSTL);
        end
      end
      apply(1'b0, 4'd0, 4'd0, 1'b0, rep == 0, 1'b0, 4'd0, 1'b0);
      n_checks++;
      if (outs() !== IDLE) begin
        n_fail++; $display("FAIL md_release rep%0d: got %b want %b", rep, outs(), IDLE);
      end
    end
    idle();
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL md_after: got %b want %b", outs(), IDLE);
    end
  endtask

  task automatic test_priority();
    apply(1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
    n_checks++;
    if (outs() !== FLUSH) begin
      n_fail++; $display("FAIL prio_flush: got %b want %b", outs(), FLUSH);
    end
    idle();
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL prio_stay_run: got %b want %b", outs(), IDLE);
    end
  endtask

  task automatic test_abort();
    apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle();
    idle();
    apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    n_checks++;
    if (outs() !== FLUSH) begin
      n_fail++; $display("FAIL abort_flush: got %b want %b", outs(), FLUSH);
    end
    idle();
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL abort_run: got %b want %b", outs(), IDLE);
    end
  endtask

  task automatic test_reset_muldiv();
    apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle();
    apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    n_checks++;
    if (outs() !== MDSTL) begin
      n_fail++; $display("FAIL rstmd_before: got %b want %b", outs(), MDSTL);
    end
    idle();
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL rstmd_after: got %b want %b", outs(), IDLE);
    end
    idle();
    n_checks++;
    if (outs() !== IDLE) begin
      n_fail++; $display("FAIL rstmd_no_resume: got %b want %b", outs(), IDLE);
    end
  endtask

  task automatic test_muldiv1();
    apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int rep = 0; rep < 2; rep++) begin
      apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      n_checks++;
      if (outs1() !== MDSTL) begin
        n_fail++; $display("FAIL md1_stall rep%0d: got %b want %b", rep, outs1(), MDSTL);
      end
      apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      n_checks++;
      if (outs1() !== IDLE) begin
        n_fail++; $display("FAIL md1_release rep%0d: got %b want %b", rep, outs1(), IDLE);
      end
    end
    idle();
  endtask

  task automatic test_stats();
    logic [15:0] want;
    apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i < N; i++) idle();
    idle();
    apply(1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
    idle();
    apply(1'b0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0);
    idle();
`ifdef HAZARD_STATS_EN
    want = 16'd10;
`else
    want = 16'd0;
`endif
    n_checks++;
    if (stallCycles !== want) begin
      n_fail++; $display("FAIL stats_count: got %0d want %0d", stallCycles, want);
    end
`ifdef HAZARD_STATS_EN
    dut.r_stall_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) apply(1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
    idle();
    n_checks++;
    if (stallCycles !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_saturate: got %h want ffff", stallCycles);
    end
`endif
  endtask

  // Reference model: remaining multiply/divide stall cycles plus a release flag.
  task automatic test_random();
    int          md_left = 0;
    bit          rel = 0;
    int          exp_stat = 0;
    logic [4:0]  e;
    bit          lu;
    apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      apply(($urandom % 40) == 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom), ($urandom % 6) == 0, 1'($urandom),
            4'($urandom_range(0, 3)), ($urandom % 10) == 0);
      lu = exMemRead && exRd != 0 && (exRd == idRs || (idUsesRt && exRd == idRt));
      if (md_left > 0)      e = branchTaken ? FLUSH : MDSTL;
      else if (rel)         e = branchTaken ? FLUSH : IDLE;
      else if (branchTaken) e = FLUSH;
      else if (lu)          e = LUSTL;
      else if (idIsMulDiv)  e = MDSTL;
      else                  e = IDLE;
      n_checks++;
      if (outs() !== e) begin
        n_fail++; $display("FAIL rand_outs cyc%0d: got %b want %b", cyc, outs(), e);
      end
`ifdef HAZARD_STATS_EN
      n_checks++;
      if (stallCycles !== 16'(exp_stat)) begin
        n_fail++; $display("FAIL rand_stats cyc%0d: got %0d want %0d", cyc, stallCycles, exp_stat);
      end
`else
      n_checks++;
      if (stallCycles !== 16'd0) begin
        n_fail++; $display("FAIL rand_stats cyc%0d: got %0d want 0", cyc, stallCycles);
      end
`endif
      if (reset) begin
        md_left = 0; rel = 0; exp_stat = 0;
      end else begin
        if (e[4] && exp_stat < 65535) exp_stat++;
        if (md_left > 0) begin
          if (branchTaken) md_left = 0;
          else begin
            md_left--;
            rel = (md_left == 0);
          end
        end else if (rel) begin
          rel = 0;
        end else if (!branchTaken && !lu && idIsMulDiv) begin
          md_left = N - 1;
          rel = (md_left == 0);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_muldiv();
    test_priority();
    test_abort();
    test_reset_muldiv();
    test_muldiv1();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
